// File: rtl/fetch_stage.sv
// fetch_stage: instruction-fetch stage.
// Owns the program counter, presents it as a word address to the instruction
// memory (combinational read), and captures the returned instruction together
// with its PC in the IF/ID pipeline register. Branch redirects reload the PC
// and flush whatever is held in IF/ID.
//
// Optional build macro FETCH_PERF_CNT_EN adds two read-only performance
// counters (perf_fetched, perf_flushed). Without it those ports do not exist.

`ifndef WIDTH
`define WIDTH 32
`endif

module fetch_stage #(
  parameter int          INST_W   = `WIDTH,
  parameter logic [31:0] RESET_PC = 32'd0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              run,
  output logic [31:0]       imem_pc,
  input  logic [INST_W-1:0] imem_inst,
  input  logic              redir_valid,
  input  logic [31:0]       redir_target,
  output logic              if_valid,
  output logic [INST_W-1:0] if_inst,
  output logic [31:0]       if_pc,
  input  logic              id_ready
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0]       perf_fetched,
  output logic [31:0]       perf_flushed
`endif
);

  // Architectural state
  logic [31:0]       pc_r;
  logic              if_valid_r;
  logic [INST_W-1:0] if_inst_r;
  logic [31:0]       if_pc_r;

  // Next-state values
  logic [31:0]       pc_s;
  logic              if_valid_s;
  logic [INST_W-1:0] if_inst_s;
  logic [31:0]       if_pc_s;

  // Per-edge event decode
  logic adv_s;
  logic fetch_s;
  logic flush_s;

  // The IF/ID slot can take a new entry when it is empty or decode is
  // consuming the current one this cycle.
  assign adv_s   = !if_valid_r || id_ready;
  // A real fetch happens only when no redirect overrides the slot update.
  assign fetch_s = adv_s && run && !redir_valid;
  // A flush is counted only when a valid wrong-path instruction is dropped.
  assign flush_s = redir_valid && if_valid_r;

  // Next-state selection: redirect beats advance, advance beats hold.
  always_comb begin
    pc_s       = pc_r;
    if_valid_s = if_valid_r;
    if_inst_s  = if_inst_r;
    if_pc_s    = if_pc_r;
    if (redir_valid) begin
      // Flush regardless of id_ready; keep the stale payload, only the
      // valid bit matters downstream.
      pc_s       = redir_target;
      if_valid_s = 1'b0;
    end else if (adv_s) begin
      if (run) begin
        if_inst_s  = imem_inst;
        if_pc_s    = pc_r;
        if_valid_s = 1'b1;
        // Natural 32-bit wrap from 32'hFFFFFFFF to 0.
        pc_s       = pc_r + 32'd1;
      end else begin
        // Drain: the slot empties, the PC is frozen so nothing is skipped.
        if_valid_s = 1'b0;
      end
    end else begin
      // Stall: decode is holding off a valid instruction; keep everything.
      pc_s       = pc_r;
      if_valid_s = if_valid_r;
    end
  end

  // PC and IF/ID register update with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pc_r       <= RESET_PC;
      if_valid_r <= 1'b0;
      if_inst_r  <= {INST_W{1'b0}};
      if_pc_r    <= 32'd0;
    end else begin
      pc_r       <= pc_s;
      if_valid_r <= if_valid_s;
      if_inst_r  <= if_inst_s;
      if_pc_r    <= if_pc_s;
    end
  end

  assign imem_pc  = pc_r;
  assign if_valid = if_valid_r;
  assign if_inst  = if_inst_r;
  assign if_pc    = if_pc_r;

`ifdef FETCH_PERF_CNT_EN
  logic [31:0] perf_fetched_r;
  logic [31:0] perf_flushed_r;

  // Performance counters: fetched instructions and flushed valid slots.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      perf_fetched_r <= 32'd0;
      perf_flushed_r <= 32'd0;
    end else begin
      if (fetch_s) begin
        perf_fetched_r <= perf_fetched_r + 32'd1;
      end else begin
        perf_fetched_r <= perf_fetched_r;
      end
      if (flush_s) begin
        perf_flushed_r <= perf_flushed_r + 32'd1;
      end else begin
        perf_flushed_r <= perf_flushed_r;
      end
    end
  end

  assign perf_fetched = perf_fetched_r;
  assign perf_flushed = perf_flushed_r;
`else
  // Event decode unused when counters are compiled out.
  logic unused_s;
  assign unused_s = fetch_s ^ flush_s;
`endif

endmodule
